// File: rtl/day1_ascii_feeder.sv
// day1_ascii_feeder
// Turns an ASCII puzzle stream into the Day 1 summer's strobe interface.
// Each number line becomes one strobed value. A blank line becomes a 0x0000
// group separator, but only after a nonzero value. An in_last character
// triggers a flush of pending digits plus a single terminating 0x0000.
module day1_ascii_feeder #(
    parameter int VAL_W     = 16,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_char,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [VAL_W-1:0] par_input,
    output logic             next_val,
    output logic [15:0]      val_count,
    output logic             overflow,
    output logic             bad_char,
    output logic             done
);

    typedef enum logic [2:0] {
        ST_ACCUM = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    // The phase counter runs 0..LEN-1 inside SETUP, PULSE and HOLD.
    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] phase_last;
    logic             phase_end;

    logic [VAL_W-1:0] acc;
    logic             digits_seen;
    logic             emitted;      // at least one value strobed since reset
    logic             last_nz;      // the most recent emission was nonzero
    logic             flush_pend;   // an in_last character is being flushed
    logic             armed;        // holds in_ready low for the first cycle out of reset

    logic             is_digit;
    logic             is_lf;
    logic             is_cr;
    logic [3:0]       digit;
    logic [VAL_W+3:0] acc_mul;
    logic             acc_sat;
    logic             accept;
    logic             sep_ok;
    logic             have_val;
    logic             lf_emit;
    logic             flush_emit;
    logic             start_emit;
    logic [VAL_W-1:0] emit_val;
    logic             hold_end;
    logic             pulse_start;
    logic             done_set;

    // Character decode and decimal accumulate. The accumulate is widened so
    // that saturation can be detected without wrapping.
    always_comb begin
        is_digit = (in_char >= 8'h30) && (in_char <= 8'h39);
        is_lf    = (in_char == 8'h0A);
        is_cr    = (in_char == 8'h0D);
        digit    = in_char[3:0];
        acc_mul  = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
                 + {{VAL_W{1'b0}}, digit};
        acc_sat  = |acc_mul[VAL_W+3:VAL_W];
    end

    // Emission decisions. A separator is only meaningful after a nonzero value.
    always_comb begin
        accept      = in_valid && in_ready;
        sep_ok      = emitted && last_nz;
        have_val    = digits_seen || sep_ok;
        lf_emit     = accept && is_lf && have_val;
        flush_emit  = (state == ST_FLUSH) && have_val;
        start_emit  = lf_emit || flush_emit;
        emit_val    = digits_seen ? acc : '0;
        hold_end    = (state == ST_HOLD) && phase_end;
        pulse_start = (state == ST_SETUP) && phase_end;
        // A flush ends after a zero emission (no terminator needed) or from
        // FLUSH when there is nothing left to send.
        done_set    = (hold_end && flush_pend && (par_input == '0))
                    || ((state == ST_FLUSH) && !have_val);
    end

    // Select the terminal count for the current strobe phase.
    always_comb begin
        phase_last = '0;
        case (state)
            ST_SETUP: phase_last = SETUP_LAST;
            ST_PULSE: phase_last = PULSE_LAST;
            ST_HOLD:  phase_last = HOLD_LAST;
            default:  phase_last = '0;
        endcase
        phase_end = (cnt == phase_last);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCUM: begin
                if (lf_emit) begin
                    state_nxt = ST_SETUP;
                end else if (accept && in_last) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_SETUP: if (phase_end) state_nxt = ST_PULSE;
            ST_PULSE: if (phase_end) state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (phase_end) begin
                    // A nonzero value emitted during a flush still owes a terminator.
                    state_nxt = (flush_pend && (par_input != '0)) ? ST_FLUSH : ST_ACCUM;
                end
            end
            ST_FLUSH: state_nxt = have_val ? ST_SETUP : ST_ACCUM;
            default:  state_nxt = ST_ACCUM;
        endcase
    end

    // Output decode.
    always_comb begin
        in_ready = armed && (state == ST_ACCUM);
        next_val = (state == ST_PULSE);
    end

    // Phase counter restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (!phase_end) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Accumulator, emitted value, sticky flags and strobe counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed       <= 1'b0;
            acc         <= '0;
            digits_seen <= 1'b0;
            par_input   <= '0;
            emitted     <= 1'b0;
            last_nz     <= 1'b0;
            flush_pend  <= 1'b0;
            val_count   <= '0;
            overflow    <= 1'b0;
            bad_char    <= 1'b0;
            done        <= 1'b0;
        end else begin
            armed <= 1'b1;
            done  <= done_set;

            if (start_emit) begin
                par_input   <= emit_val;
                emitted     <= 1'b1;
                last_nz     <= (emit_val != '0);
                acc         <= '0;
                digits_seen <= 1'b0;
            end else if (accept && is_digit) begin
                acc         <= acc_sat ? '1 : acc_mul[VAL_W-1:0];
                digits_seen <= 1'b1;
                if (acc_sat) overflow <= 1'b1;
            end

            if (accept && !is_digit && !is_lf && !is_cr) begin
                bad_char <= 1'b1;
            end

            if (pulse_start) begin
                val_count <= val_count + 16'd1;
            end

            if (accept && in_last) begin
                flush_pend <= 1'b1;
            end else if (done_set) begin
                flush_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_day1_ascii_feeder.sv
// Bench for day1_ascii_feeder: a character-level model predicts the strobe
// sequence and a negedge monitor checks values, strobe timing and counters.
module tb_day1_ascii_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_char;
    logic        drv_valid;
    logic        in_last;
    logic        sel;          // 0: default timing DUT, 1: 2/3/2 timing DUT

    logic        in_valid1, in_valid2;
    logic        rdy1, nv1, ovf1, bad1, done1;
    logic        rdy2, nv2, ovf2, bad2, done2;
    logic [15:0] par1, cnt1, par2, cnt2;

    logic        rdy, nv, ovf, bad, dn;
    logic [15:0] par, vcnt;

    always #5 clk = ~clk;

    assign in_valid1 = drv_valid && !sel;
    assign in_valid2 = drv_valid && sel;
    assign rdy  = sel ? rdy2  : rdy1;
    assign nv   = sel ? nv2   : nv1;
    assign ovf  = sel ? ovf2  : ovf1;
    assign bad  = sel ? bad2  : bad1;
    assign dn   = sel ? done2 : done1;
    assign par  = sel ? par2  : par1;
    assign vcnt = sel ? cnt2  : cnt1;

    day1_ascii_feeder u_dut1 (
        .clk(clk), .rst(rst), .in_char(in_char), .in_valid(in_valid1), .in_last(in_last),
        .in_ready(rdy1), .par_input(par1), .next_val(nv1), .val_count(cnt1),
        .overflow(ovf1), .bad_char(bad1), .done(done1)
    );

    day1_ascii_feeder #(.VAL_W(16), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_char(in_char), .in_valid(in_valid2), .in_last(in_last),
        .in_ready(rdy2), .par_input(par2), .next_val(nv2), .val_count(cnt2),
        .overflow(ovf2), .bad_char(bad2), .done(done2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    logic [15:0] lit[$];
    int m_acc;
    bit m_dig, m_emitted, m_last_nz, m_ovf, m_bad;
    int m_done;
    int done_cnt;

    function automatic void m_emit(input int v);
        exp_q.push_back(16'(v));
        m_emitted = 1'b1;
        m_last_nz = (v != 0);
        m_acc = 0;
        m_dig = 1'b0;
    endfunction

    function automatic void model_feed(input logic [7:0] c, input bit last);
        if (c >= "0" && c <= "9") begin
            m_acc = m_acc * 10 + int'(c - "0");
            if (m_acc > 65535) begin
                m_acc = 65535;
                m_ovf = 1'b1;
            end
            m_dig = 1'b1;
        end else if (c == 8'h0A) begin
            if (m_dig) m_emit(m_acc);
            else if (m_emitted && m_last_nz) m_emit(0);
        end else if (c != 8'h0D) begin
            m_bad = 1'b1;
        end
        if (last) begin
            if (m_dig) m_emit(m_acc);
            if (m_emitted && m_last_nz) m_emit(0);
            m_done++;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_acc = 0; m_dig = 0; m_emitted = 0; m_last_nz = 0;
        m_ovf = 0; m_bad = 0; m_done = 0;
    endfunction

    // ---------------- monitor ----------------
    bit          prev_nv, prev_rdy, prev_done;
    int          hi_len, hold_left, run_len, run_str, cnt_model;
    int          sc, pc, hc;
    logic [15:0] strobe_val, e;
    logic [15:0] h_par [0:3];
    bit          h_nv  [0:3];
    bit          h_rdy [0:3];

    always @(negedge clk) begin
        if (rst) begin
            prev_nv = 0; prev_rdy = 0; prev_done = 0;
            hi_len = 0; hold_left = 0; run_len = 0; run_str = 0;
            cnt_model = 0; done_cnt = 0;
            for (int i = 0; i < 4; i++) begin
                h_par[i] = '0; h_nv[i] = 0; h_rdy[i] = 0;
            end
        end else begin
            sc = sel ? 2 : 1;
            pc = sel ? 3 : 1;
            hc = sel ? 2 : 1;
            if (nv && !prev_nv) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL strobe_unexpected: got value %0h, none expected", par);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_value", par, e);
                end
                obs_q.push_back(par);
                cnt_model++;
                chk("val_count", vcnt, 32'(16'(cnt_model)));
                for (int i = 0; i < sc; i++) begin
                    chk("setup_stable", h_par[i], par);
                    chk("setup_nv_low", h_nv[i], 0);
                    chk("setup_rdy_low", h_rdy[i], 0);
                end
                strobe_val = par;
                hi_len = 0;
                run_str++;
            end
            if (nv) begin
                hi_len++;
                chk("pulse_stable", par, strobe_val);
                chk("pulse_rdy_low", rdy, 0);
            end
            if (!nv && prev_nv) begin
                chk("pulse_len", hi_len, pc);
                hold_left = hc;
            end
            if (!nv && hold_left > 0) begin
                chk("hold_stable", par, strobe_val);
                chk("hold_rdy_low", rdy, 0);
                hold_left--;
            end
            if (!rdy) begin
                run_len++;
            end else if (!prev_rdy) begin
                if (run_str == 1 && !dn) chk("rdy_low_len", run_len, sc + pc + hc);
                run_len = 0;
                run_str = 0;
            end
            if (dn) begin
                done_cnt++;
                chk("done_with_rdy", rdy, 1);
                chk("done_single", prev_done, 0);
            end
            for (int i = 3; i > 0; i--) begin
                h_par[i] = h_par[i-1]; h_nv[i] = h_nv[i-1]; h_rdy[i] = h_rdy[i-1];
            end
            h_par[0] = par; h_nv[0] = nv; h_rdy[0] = rdy;
            prev_nv = nv; prev_rdy = rdy; prev_done = dn;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input string s, input bit last);
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] c;
            bit l;
            bit ok;
            int n;
            c = s[i];
            l = last && (i == s.len() - 1);
            model_feed(c, l);
            ok = 0;
            n = 0;
            while (!ok && n < 100) begin
                @(negedge clk);
                in_char = c; drv_valid = 1'b1; in_last = l;
                ok = rdy;
                @(posedge clk);
                n++;
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL accept_timeout: char %0h not accepted, in_ready stayed 0", c);
            end
        end
        @(negedge clk);
        drv_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) begin
            checks++; errors++;
            $display("FAIL done_timeout: done count %0d, expected %0d", done_cnt, target);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_obs(input string name);
        chk({name, "_count"}, obs_q.size(), lit.size());
        foreach (lit[i]) if (i < obs_q.size()) chk(name, obs_q[i], lit[i]);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic do_reset(input bit new_sel);
        @(negedge clk);
        rst = 1'b1;
        sel = new_sel;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        rst = 1'b1; drv_valid = 1'b0; in_last = 1'b0; in_char = 8'h00; sel = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_in_ready", rdy1, 0);
        chk("rst_par_input", par1, 0);
        chk("rst_next_val", nv1, 0);
        chk("rst_val_count", cnt1, 0);
        chk("rst_overflow", ovf1, 0);
        chk("rst_bad_char", bad1, 0);
        chk("rst_done", done1, 0);
        chk("rst_in_ready2", rdy2, 0);
        rst = 1'b0;
        #1 chk("rdy_after_release", rdy1, 0);
        @(negedge clk);
        chk("rdy_first_edge", rdy1, 1);

        // Basic stream, default timing.
        obs_q.delete();
        send("1000\n2000\n3000\n\n4000\n", 1'b1);
        wait_done(m_done);
        lit.delete();
        lit.push_back(16'h03E8); lit.push_back(16'h07D0); lit.push_back(16'h0BB8);
        lit.push_back(16'h0000); lit.push_back(16'h0FA0); lit.push_back(16'h0000);
        check_obs("basic");
        chk("basic_val_count", cnt1, 6);
        chk("basic_done_count", done_cnt, 1);

        // Blank-line collapsing and flush of pending digits.
        obs_q.delete();
        send("\n\n5000\n\n\n6000", 1'b1);
        wait_done(m_done);
        lit.delete();
        lit.push_back(16'h1388); lit.push_back(16'h0000);
        lit.push_back(16'h1770); lit.push_back(16'h0000);
        check_obs("blank");
        chk("blank_done_count", done_cnt, m_done);
        chk("blank_val_count", cnt1, 10);

        // Saturation.
        obs_q.delete();
        send("70000\n5\n", 1'b0);
        repeat (12) @(negedge clk);
        lit.delete();
        lit.push_back(16'hFFFF); lit.push_back(16'h0005);
        check_obs("ovf");
        chk("overflow_set", ovf1, 1);
        chk("overflow_model", ovf1, 32'(m_ovf));

        // CR is silent; other characters flag bad_char.
        obs_q.delete();
        send("\r", 1'b0);
        repeat (3) @(negedge clk);
        chk("cr_no_flag", bad1, 0);
        send("12a3\r\n", 1'b0);
        repeat (12) @(negedge clk);
        lit.delete();
        lit.push_back(16'h007B);
        check_obs("bad");
        chk("bad_char_set", bad1, 1);
        chk("bad_model", bad1, 32'(m_bad));

        // Reset while next_val is high.
        do_reset(1'b0);
        obs_q.delete();
        send("9\n", 1'b0);
        begin
            int n;
            n = 0;
            while (!nv1 && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("nv_before_rst", nv1, 1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_next_val", nv1, 0);
        chk("async_par_input", par1, 0);
        chk("async_val_count", cnt1, 0);
        chk("async_in_ready", rdy1, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        obs_q.delete();
        send("7\n", 1'b0);
        repeat (12) @(negedge clk);
        lit.delete();
        lit.push_back(16'h0007);
        check_obs("after_rst");
        chk("after_rst_val_count", cnt1, 1);

        // Stretched strobe timing 2/3/2 on the second instance.
        do_reset(1'b1);
        obs_q.delete();
        send("1000\n2000\n3000\n\n4000\n", 1'b1);
        wait_done(m_done);
        lit.delete();
        lit.push_back(16'h03E8); lit.push_back(16'h07D0); lit.push_back(16'h0BB8);
        lit.push_back(16'h0000); lit.push_back(16'h0FA0); lit.push_back(16'h0000);
        check_obs("slow");
        chk("slow_val_count", cnt2, 6);
        chk("slow_done_count", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
